core_axil_master: RTL and testbench

AXI4-Lite initiator for the core's load/store path. Accepts one word-sized load or store from the LSU over a simple valid/ready request port and drives the AXI4-Lite read or write channels to the data-memory responder. Returns read data and a status on a single-cycle response strobe. Sits between the core pipeline and the data-memory AXI4-Lite bus, and supports at most one outstanding transaction.

---
 rtl/core_pkg.sv | 28 ++
 rtl/core_axil_master.sv | 206 ++++++++++++++++++++
 tb/tb_core_axil_master.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the core's load/store path: LSU response status,
// AXI4-Lite initiator state and the AXI response codes.
package core_pkg;

    typedef enum logic [1:0] {
        LSU_OKAY       = 2'd0,
        LSU_BUS_ERR    = 2'd1,
        LSU_MISALIGNED = 2'd2
    } t_lsu_status;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP
    } t_axil_state;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Any non-OKAY response (EXOKAY included, which AXI4-Lite does not allow) is an error.
    function automatic t_lsu_status resp_to_status(input logic [1:0] resp);
        return (resp == AXI_RESP_OKAY) ? LSU_OKAY : LSU_BUS_ERR;
    endfunction

endpackage

// File: rtl/core_axil_master.sv
// AXI4-Lite initiator for single word loads/stores from the LSU.
// One outstanding transaction; all outputs registered except req_ready.
module core_axil_master
    import core_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic              clk,
    input  logic              areset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,

    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_status,

    output logic [ADDR_W-1:0] axi_awaddr,
    output logic [2:0]        axi_awprot,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [31:0]       axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,

    output logic [ADDR_W-1:0] axi_araddr,
    output logic [2:0]        axi_arprot,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [31:0]       axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready
);

    t_axil_state       state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    t_lsu_status       rsp_status_q, rsp_status_d;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q & axi_awready;
    assign w_hs  = wvalid_q & axi_wready;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        awaddr_d     = awaddr_q;
        araddr_d     = araddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_addr[1:0] != 2'b00) begin
                        rsp_valid_d  = 1'b1;
                        rsp_rdata_d  = '0;
                        rsp_status_d = LSU_MISALIGNED;
                    end else if (req_we) begin
                        state_d   = S_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = req_addr;
                    end
                end
            end

            S_RD_ADDR: begin
                if (arvalid_q && axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (rready_q && axi_rvalid) begin
                    rready_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = axi_rdata;
                    rsp_status_d = resp_to_status(axi_rresp);
                    state_d      = S_IDLE;
                end
            end

            S_WR_REQ: begin
                // AW and W retire independently; bready rises on the edge of whichever finishes last.
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (bready_q && axi_bvalid) begin
                    bready_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_status_d = resp_to_status(axi_bresp);
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= LSU_OKAY;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_status  = rsp_status_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awprot  = PROT;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = araddr_q;
    assign axi_arprot  = PROT;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

endmodule

// File: tb/tb_core_axil_master.sv
// Bench for core_axil_master: directed requests against a latency-configurable
// AXI4-Lite memory responder, with a response scoreboard and payload-stability monitor.
module tb_core_axil_master;
    import core_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [3:0]        req_wstrb = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_status;
    logic [ADDR_W-1:0] axi_awaddr;
    logic [2:0]        axi_awprot;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic [ADDR_W-1:0] axi_araddr;
    logic [2:0]        axi_arprot;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [31:0]       axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic              axi_rready;

    core_axil_master #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
        .clk(clk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: each ready rises once its valid has been high for *_lat cycles.
    int ar_lat = 0, aw_lat = 0, w_lat = 0;
    bit r_err = 1'b0, b_err = 1'b0;
    logic [31:0]       mem [0:15];
    int                ar_cnt, aw_cnt, w_cnt;
    bit                aw_got, w_got;
    logic [ADDR_W-1:0] aw_addr_l;
    logic [31:0]       w_data_l;
    logic [3:0]        w_strb_l;
    int                ar_hs, aw_hs, w_hs, b_hs;

    assign axi_arready = axi_arvalid && (ar_cnt >= ar_lat);
    assign axi_awready = axi_awvalid && (aw_cnt >= aw_lat);
    assign axi_wready  = axi_wvalid && (w_cnt >= w_lat);

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i * 20);
            ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            axi_rvalid <= 1'b0; axi_rdata <= '0; axi_rresp <= '0;
            axi_bvalid <= 1'b0; axi_bresp <= '0;
            ar_hs <= 0; aw_hs <= 0; w_hs <= 0; b_hs <= 0;
        end else begin
            if (axi_arvalid && axi_arready) begin
                ar_cnt     <= 0;
                ar_hs      <= ar_hs + 1;
                axi_rvalid <= 1'b1;
                axi_rdata  <= r_err ? 32'hDEAD_BEEF : mem[axi_araddr[5:2]];
                axi_rresp  <= r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (axi_arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (axi_rvalid && axi_rready) axi_rvalid <= 1'b0;

            if (axi_awvalid && axi_awready) begin
                aw_cnt <= 0; aw_hs <= aw_hs + 1;
                aw_got <= 1'b1; aw_addr_l <= axi_awaddr;
            end else if (axi_awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (axi_wvalid && axi_wready) begin
                w_cnt <= 0; w_hs <= w_hs + 1;
                w_got <= 1'b1; w_data_l <= axi_wdata; w_strb_l <= axi_wstrb;
            end else if (axi_wvalid) begin
                w_cnt <= w_cnt + 1;
            end

            // B is a one-cycle pulse; the initiator must already have bready up.
            if (axi_bvalid) begin
                axi_bvalid <= 1'b0;
                if (axi_bready) b_hs <= b_hs + 1;
            end
            if (aw_got && w_got) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_l[b]) mem[aw_addr_l[5:2]][8*b +: 8] <= w_data_l[8*b +: 8];
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                axi_bvalid <= 1'b1;
                axi_bresp  <= b_err ? AXI_RESP_DECERR : AXI_RESP_OKAY;
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  status;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;

    always @(negedge clk) begin
        if (!areset && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, exp_e.rdata);
                check("rsp_status", rsp_status, exp_e.status);
            end
        end
    end

    // Payload must hold while its valid waits for ready.
    logic              aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [ADDR_W-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [31:0]       prev_wdata = '0;
    logic [3:0]        prev_wstrb = '0;

    always @(negedge clk) begin
        if (areset) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (aw_pend) begin
                check("awvalid_held", axi_awvalid, 1'b1);
                check("awaddr_stable", axi_awaddr, prev_awaddr);
            end
            if (w_pend) begin
                check("wvalid_held", axi_wvalid, 1'b1);
                check("wdata_stable", {axi_wstrb, axi_wdata}, {prev_wstrb, prev_wdata});
            end
            if (ar_pend) begin
                check("arvalid_held", axi_arvalid, 1'b1);
                check("araddr_stable", axi_araddr, prev_araddr);
            end
            aw_pend     <= axi_awvalid && !axi_awready;
            w_pend      <= axi_wvalid && !axi_wready;
            ar_pend     <= axi_arvalid && !axi_arready;
            prev_awaddr <= axi_awaddr;
            prev_araddr <= axi_araddr;
            prev_wdata  <= axi_wdata;
            prev_wstrb  <= axi_wstrb;
        end
    end

    // Issue one request from just after a rising edge; returns the cycle (1 = cycle after
    // acceptance) in which rsp_valid was seen, and channel-valid cycle counts meanwhile.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_status, output int lat, output int aw_cyc,
                          output int w_cyc, output int ar_cyc, output logic arv_c1,
                          output logic [31:0] araddr_c1);
        int guard = 0;
        lat = 0; aw_cyc = 0; w_cyc = 0; ar_cyc = 0; arv_c1 = 1'b0; araddr_c1 = '0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!req_ready) check("req_ready_wait", req_ready, 1'b1);
        exp_q.push_back('{exp_rdata, exp_status});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            aw_cyc += int'(axi_awvalid);
            w_cyc  += int'(axi_wvalid);
            ar_cyc += int'(axi_arvalid);
            if (n == 1) begin
                arv_c1    = axi_arvalid;
                araddr_c1 = axi_araddr;
            end
            if (rsp_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) begin
            check("rsp_timeout", 64'(lat), 64'd1);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    int          lat, awc, wc, arc;
    int          aw0, w0, b0, ar0;
    logic        arv1;
    logic [31:0] a1;

    initial begin
        #1 areset = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 3'b000);
        check("rst_readies", {axi_bready, axi_rready}, 2'b00);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_status}, {1'b0, 32'h0, LSU_OKAY});
        check("rst_payload", {axi_awaddr, axi_araddr, axi_wdata, axi_wstrb}, 100'h0);
        check("rst_prot", {axi_awprot, axi_arprot}, 6'b000000);
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk); #1;

        // Load word1 through a responder that answers one cycle after valid.
        ar_lat = 1;
        do_req(1'b0, 32'h4, 32'h0, 4'h0, 32'h14, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("ld_lat_reg", lat, 4);
        check("ld_arvalid_c1", arv1, 1'b1);
        check("ld_araddr_c1", a1, 32'h4);

        ar_lat = 0;
        do_req(1'b0, 32'h4, 32'h0, 4'h0, 32'h14, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("ld_lat_zero", lat, 3);

        // Full-word store to word2, then read it back.
        aw_lat = 1; w_lat = 1; ar_lat = 1;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        do_req(1'b1, 32'h8, 32'h1E, 4'hF, 32'h0, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("st_lat_reg", lat, 5);
        check("st_aw_count", aw_hs - aw0, 1);
        check("st_w_count", w_hs - w0, 1);
        check("st_b_count", b_hs - b0, 1);
        check("st_mem_word2", mem[2], 32'h1E);
        do_req(1'b0, 32'h8, 32'h0, 4'h0, 32'h1E, LSU_OKAY, lat, awc, wc, arc, arv1, a1);

        // Zero-wait partial store to word8 (reset value 160 = 0xA0).
        aw_lat = 0; w_lat = 0;
        do_req(1'b1, 32'h20, 32'h1122_3344, 4'b1100, 32'h0, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("st_lat_zero", lat, 4);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_00A0, LSU_OKAY, lat, awc, wc, arc, arv1, a1);

        // AW stalled three cycles, W immediate; word3 reset value 60 = 0x3C.
        aw_lat = 3; w_lat = 0;
        b0 = b_hs;
        do_req(1'b1, 32'hC, 32'hA5A5_1234, 4'b0011, 32'h0, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("st_wvalid_cycles", wc, 1);
        check("st_awvalid_cycles", awc, 4);
        check("st_b_once", b_hs - b0, 1);
        check("st_lat_aw_stall", lat, 7);
        check("st_mem_word3", mem[3], 32'h0000_1234);

        // Misaligned requests never reach the bus.
        aw_lat = 1; w_lat = 1;
        ar0 = ar_hs; aw0 = aw_hs;
        do_req(1'b0, 32'h6, 32'h0, 4'h0, 32'h0, LSU_MISALIGNED, lat, awc, wc, arc, arv1, a1);
        check("mis_ld_lat", lat, 1);
        check("mis_ld_arvalid", arc, 0);
        do_req(1'b1, 32'h9, 32'h77, 4'hF, 32'h0, LSU_MISALIGNED, lat, awc, wc, arc, arv1, a1);
        check("mis_st_lat", lat, 1);
        check("mis_st_valids", awc + wc, 0);
        check("mis_no_handshakes", (ar_hs - ar0) + (aw_hs - aw0), 0);

        // Error responses: rdata passes through on a failed load, stays 0 on a failed store.
        r_err = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, LSU_BUS_ERR, lat, awc, wc, arc, arv1, a1);
        r_err = 1'b0;
        b_err = 1'b1;
        do_req(1'b1, 32'h14, 32'h55, 4'hF, 32'h0, LSU_BUS_ERR, lat, awc, wc, arc, arv1, a1);
        b_err = 1'b0;

        // Reset in the middle of a store with AW held off.
        aw_lat = 8; w_lat = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18; req_wdata = 32'h99; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_st_awvalid", axi_awvalid, 1'b1);
        #2 areset = 1'b1;
        #1;
        check("arst_valids", {axi_awvalid, axi_wvalid, axi_arvalid}, 3'b000);
        check("arst_readies", {axi_bready, axi_rready, rsp_valid}, 3'b000);
        check("arst_awaddr", axi_awaddr, 32'h0);
        @(posedge clk);
        #3 areset = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1'b1);
        aw_lat = 1; ar_lat = 1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h4, 32'h0, 4'h0, 32'h14, LSU_OKAY, lat, awc, wc, arc, arv1, a1);
        check("post_rst_ld_lat", lat, 4);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
